// File: rtl/ddr_wr_packer_if.sv
// Stream bundle for ddr_wr_packer: result-word input side and DDR write-beat output side.
// Latency: none, signal container only.
// Backpressure: ready_in throttles the word source, ready_out throttles the packer.
interface ddr_wr_packer_if #(
  parameter int IN_WIDTH  = 324,
  parameter int OUT_WIDTH = 256
);
  logic [IN_WIDTH-1:0]  data_in;
  logic                 valid_in;
  logic                 ready_in;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 valid_out;
  logic                 ready_out;
  logic                 last_out;

  // Packer side
  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out, last_out
  );

  // Environment side: word source plus DDR write sink
  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out, last_out
  );
endinterface

// File: rtl/ddr_wr_packer.sv
// Packs NUM_IN result words (IN_WIDTH) LSB-first into NUM_OUT DDR beats (OUT_WIDTH), zero-padding the last beat.
// Latency: a beat is valid the cycle after enough bits are registered; done follows the final accepted beat.
// Backpressure: ready_out low stalls beats losslessly; ready_in drops while more than one beat is buffered.
// Optional: define DDR_WR_PACKER_BYTE_SWAP_EN to byte-reverse every beat for big-endian DDR controllers.
module ddr_wr_packer #(
  parameter int IN_WIDTH  = 324,
  parameter int OUT_WIDTH = 256,
  parameter int NUM_IN    = 64,
  parameter int NUM_OUT   = 81,
  parameter int CNT_WIDTH = 10
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  ddr_wr_packer_if.slave  bus
);

  localparam int ACC_W = IN_WIDTH + OUT_WIDTH;
  localparam int ICW   = $clog2(NUM_IN + 1);
  localparam int OCW   = $clog2(NUM_OUT + 1);

  localparam logic [CNT_WIDTH-1:0] OW_C       = CNT_WIDTH'(OUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] IW_C       = CNT_WIDTH'(IN_WIDTH);
  localparam logic [ICW-1:0]       NUM_IN_C   = ICW'(NUM_IN);
  localparam logic [OCW-1:0]       LAST_OUT_C = OCW'(NUM_OUT - 1);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_pop;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d, bcnt_pop;
  logic [ICW-1:0]       in_cnt_q, in_cnt_d;
  logic [OCW-1:0]       out_cnt_q, out_cnt_d;
  logic                 in_fire, out_fire;
  logic [OUT_WIDTH-1:0] beat;

  // Handshake outputs depend on registered state only, so ready_in has no path from ready_out.
  assign bus.ready_in  = (state_q == PACK) && (in_cnt_q < NUM_IN_C) && (bcnt_q <= OW_C);
  assign bus.valid_out = ((state_q == PACK) && (bcnt_q >= OW_C)) || (state_q == FLUSH);
  assign bus.last_out  = bus.valid_out && (out_cnt_q == LAST_OUT_C);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  assign in_fire  = bus.valid_in && bus.ready_in;
  assign out_fire = bus.valid_out && bus.ready_out;

  // Low beat of the accumulator; during FLUSH anything at or above bcnt is forced to zero padding.
  assign beat = acc_q[OUT_WIDTH-1:0] &
                ((state_q == FLUSH) ? ~({OUT_WIDTH{1'b1}} << bcnt_q) : {OUT_WIDTH{1'b1}});

`ifdef DDR_WR_PACKER_BYTE_SWAP_EN
  // Byte 0 of the beat lands in the top byte lane.
  for (genvar b = 0; b < OUT_WIDTH / 8; b++) begin : g_swap
    assign bus.data_out[8*b +: 8] = beat[OUT_WIDTH-8-8*b +: 8];
  end
`else
  assign bus.data_out = beat;
`endif

  // Pop stage: an accepted beat leaves the bottom of the accumulator before any new word is appended.
  always_comb begin
    acc_pop  = acc_q;
    bcnt_pop = bcnt_q;
    if (out_fire) begin
      acc_pop  = acc_q >> OUT_WIDTH;
      bcnt_pop = (bcnt_q >= OW_C) ? (bcnt_q - OW_C) : '0;
    end
  end

  // Next state, append stage and block counters.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_pop;
    bcnt_d    = bcnt_pop;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;

    if (in_fire) begin
      acc_d    = acc_pop | ({{OUT_WIDTH{1'b0}}, bus.data_in} << bcnt_pop);
      bcnt_d   = bcnt_pop + IW_C;
      in_cnt_d = in_cnt_q + 1'b1;
    end
    if (out_fire) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PACK;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      PACK: begin
        if (in_cnt_q == NUM_IN_C) begin
          if (bcnt_q == '0) begin
            state_d = DONE;
          end else if (bcnt_q < OW_C) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_fire) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        acc_d   = '0;
        bcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, valid-bit count and block counters.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      bcnt_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      bcnt_q    <= bcnt_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Bench for ddr_wr_packer: full blocks, backpressure, ignored restart, mid-block reset, flush path, byte order.
// Expected beats come from slicing the LSB-first concatenation of all words sent in a block.
// Honours DDR_WR_PACKER_BYTE_SWAP_EN when the bench is built with the same define as the RTL.
module tb_ddr_wr_packer;

  localparam int IW = 324;
  localparam int OW = 256;
  localparam int NI = 64;
  localparam int NO = 81;
  localparam int BUDGET = 4000;

  logic sys_clk = 1'b0;
  logic rst;
  logic start, busy, done;
  logic start_s, busy_s, done_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  ddr_wr_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();
  ddr_wr_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_s ();

  ddr_wr_packer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_IN(NI), .NUM_OUT(NO), .CNT_WIDTH(10)
  ) u_dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus.slave)
  );

  ddr_wr_packer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_IN(1), .NUM_OUT(2), .CNT_WIDTH(10)
  ) u_small (
    .sys_clk(sys_clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .bus(bus_s.slave)
  );

  // Lane ordering the DDR side is expected to see.
  function automatic logic [OW-1:0] ddr_order(input logic [OW-1:0] b);
    logic [OW-1:0] r;
`ifdef DDR_WR_PACKER_BYTE_SWAP_EN
    for (int i = 0; i < OW / 8; i++) r[8*i +: 8] = b[OW-1-8*i -: 8];
`else
    r = b;
`endif
    return r;
  endfunction

  task automatic clear_inputs();
    start = 1'b0;
    start_s = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.ready_out = 1'b0;
    bus_s.valid_in = 1'b0;
    bus_s.data_in = '0;
    bus_s.ready_out = 1'b0;
  endtask

  // Runs one block on the default-size DUT. abort_at >= 0 pulls rst once that many words are in.
  task automatic run_block(input bit rnd, input int rdy_pct, input bit gaps,
                           input int restart_at, input int abort_at);
    logic [IW-1:0]    words [NI];
    logic [NI*IW-1:0] stream;
    logic [OW-1:0]    held, exp;
    bit hold = 0;
    int in_idx = 0, out_idx = 0, dones = 0, cyc = 0;
    bit finished = 0;

    for (int i = 0; i < NI; i++) begin
      words[i] = '0;
      for (int j = 0; j < 11; j++)
        words[i] = (words[i] << 32) | IW'(rnd ? $urandom : 32'(i * 11 + j));
      stream[i*IW +: IW] = words[i];
    end

    while (cyc < BUDGET && !finished) begin
      @(negedge sys_clk);
      cyc++;
      if (hold) begin
        n_cmp++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== held) begin
          n_bad++;
          $display("FAIL stall_stable beat%0d: valid=%b data=%h required valid=1 data=%h",
                   out_idx, bus.valid_out, bus.data_out, held);
        end
      end
      if (done === 1'b1) begin
        dones++;
      end else if (dones > 0) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_after_done: busy=%b required 0", busy);
        end
        finished = 1;
      end
      if (!finished && abort_at >= 0 && in_idx == abort_at) begin
        clear_inputs();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.ready_in, bus.valid_out, bus.last_out, busy, done} !== 5'b0 || bus.data_out !== '0) begin
          n_bad++;
          $display("FAIL abort_outputs: rdy_in=%b vld_out=%b last=%b busy=%b done=%b data=%h required all 0",
                   bus.ready_in, bus.valid_out, bus.last_out, busy, done, bus.data_out);
        end
        @(negedge sys_clk);
        n_cmp++;
        if (done !== 1'b0 || dones != 0) begin
          n_bad++;
          $display("FAIL abort_no_done: done=%b pulses=%0d required 0", done, dones);
        end
        rst = 1'b0;
        return;
      end
      if (!finished) begin
        start = (cyc == 1) || (cyc == restart_at);
        bus.valid_in  = (in_idx < NI) && (!gaps || $urandom_range(0, 3) != 0);
        bus.data_in   = (in_idx < NI) ? words[in_idx] : '0;
        bus.ready_out = ($urandom_range(0, 99) < rdy_pct);
        hold = bus.valid_out && !bus.ready_out;
        held = bus.data_out;
        if (bus.valid_in && bus.ready_in) in_idx++;
        if (bus.valid_out && bus.ready_out) begin
          n_cmp++;
          if (out_idx >= NO) begin
            n_bad++;
            $display("FAIL extra_beat: beat index %0d required below %0d", out_idx, NO);
          end else begin
            exp = ddr_order(stream[out_idx*OW +: OW]);
            if (bus.data_out !== exp || bus.last_out !== (out_idx == NO - 1)) begin
              n_bad++;
              $display("FAIL beat%0d: data=%h last=%b required data=%h last=%b",
                       out_idx, bus.data_out, bus.last_out, exp, (out_idx == NO - 1));
            end
          end
          out_idx++;
        end
      end
    end
    clear_inputs();
    n_cmp++;
    if (!finished || in_idx != NI || out_idx != NO || dones != 1) begin
      n_bad++;
      $display("FAIL block_totals: finished=%0d words=%0d beats=%0d done_pulses=%0d required 1/%0d/%0d/1",
               finished, in_idx, out_idx, dones, NI, NO);
    end
  endtask

  // One-word block on the NUM_IN=1 / NUM_OUT=2 instance; returns the first beat seen.
  task automatic run_small(input logic [IW-1:0] w, output logic [OW-1:0] b0);
    logic [2*OW-1:0] stream;
    logic [OW-1:0]   exp;
    int got = 0, dones = 0, cyc = 0;
    bit sent = 0, finished = 0;
    stream = '0;
    stream[IW-1:0] = w;
    b0 = '0;
    while (cyc < 200 && !finished) begin
      @(negedge sys_clk);
      cyc++;
      if (done_s === 1'b1) dones++;
      else if (dones > 0) finished = 1;
      if (!finished) begin
        start_s = (cyc == 1);
        bus_s.valid_in  = !sent;
        bus_s.data_in   = w;
        bus_s.ready_out = 1'($urandom_range(0, 1));
        if (bus_s.valid_in && bus_s.ready_in) sent = 1;
        if (bus_s.valid_out && bus_s.ready_out) begin
          n_cmp++;
          if (got >= 2) begin
            n_bad++;
            $display("FAIL small_extra_beat: index %0d required below 2", got);
          end else begin
            exp = ddr_order(stream[got*OW +: OW]);
            if (bus_s.data_out !== exp || bus_s.last_out !== (got == 1)) begin
              n_bad++;
              $display("FAIL small_beat%0d: data=%h last=%b required data=%h last=%b",
                       got, bus_s.data_out, bus_s.last_out, exp, (got == 1));
            end
            if (got == 0) b0 = bus_s.data_out;
          end
          got++;
        end
      end
    end
    clear_inputs();
    n_cmp++;
    if (!finished || got != 2 || dones != 1) begin
      n_bad++;
      $display("FAIL small_totals: finished=%0d beats=%0d done_pulses=%0d required 1/2/1", finished, got, dones);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    n_cmp++;
    if ({bus.ready_in, bus.valid_out, bus.last_out, busy, done} !== 5'b0 || bus.data_out !== '0 ||
        {bus_s.ready_in, bus_s.valid_out, bus_s.last_out, busy_s, done_s} !== 5'b0 || bus_s.data_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: big=%b%b%b%b%b small=%b%b%b%b%b required all 0",
               bus.ready_in, bus.valid_out, bus.last_out, busy, done,
               bus_s.ready_in, bus_s.valid_out, bus_s.last_out, busy_s, done_s);
    end
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_no_accept();
    bus.valid_in = 1'b1;
    bus.data_in  = '1;
    bus.ready_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (bus.ready_in !== 1'b0 || busy !== 1'b0 || bus.valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_no_accept: ready_in=%b busy=%b valid_out=%b required 0/0/0",
                 bus.ready_in, busy, bus.valid_out);
      end
    end
    clear_inputs();
  endtask

  task automatic test_full_block();
    run_block(1'b0, 100, 1'b0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_block(1'b0, 50, 1'b0, -1, -1);
    run_block(1'b1, 50, 1'b1, -1, -1);
  endtask

  task automatic test_restart_ignored();
    run_block(1'b1, 70, 1'b0, 40, -1);
  endtask

  task automatic test_abort_reset();
    run_block(1'b1, 60, 1'b0, -1, 30);
    run_block(1'b1, 100, 1'b0, -1, -1);
  endtask

  task automatic test_flush_small();
    logic [OW-1:0] b0;
    run_small('1, b0);
  endtask

  task automatic test_byte_order();
    logic [OW-1:0] b0;
    logic [IW-1:0] w;
    w = '0;
    w[15:0] = 16'h0201;
    run_small(w, b0);
    n_cmp++;
`ifdef DDR_WR_PACKER_BYTE_SWAP_EN
    if (b0[255:248] !== 8'h01 || b0[247:240] !== 8'h02) begin
      n_bad++;
      $display("FAIL byte_order: byte31=%h byte30=%h required 01/02", b0[255:248], b0[247:240]);
    end
`else
    if (b0[7:0] !== 8'h01 || b0[15:8] !== 8'h02) begin
      n_bad++;
      $display("FAIL byte_order: byte0=%h byte1=%h required 01/02", b0[7:0], b0[15:8]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_no_accept();
    test_full_block();
    test_backpressure();
    test_restart_ignored();
    test_abort_reset();
    test_flush_small();
    test_byte_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
